// File: rtl/common_types_pkg.sv
// Shared types for the memory-side arbitration path.
package common_types_pkg;

   localparam int unsigned ADDR_W_DEF = 32;
   localparam int unsigned DATA_W_DEF = 32;

   // Status reported by the single-port memory and forwarded to the masters.
   typedef enum logic [1:0] {
      RAM_IDLE = 2'd0,
      RAM_WAIT = 2'd1,
      RAM_DONE = 2'd2
   } ram_state_t;

   // Ownership of the memory channel.
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_IBUSY = 2'd1,
      ARB_DBUSY = 2'd2
   } arb_state_t;

   // Master most recently granted, used for round-robin tie breaks.
   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_t;

endpackage : common_types_pkg

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of the single-port I/D memory.
// The winner of an idle cycle drives the memory in that same cycle.
module mem_arbiter
   import common_types_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic                clk,
   input  logic                nrst,
   // fetch master (read only)
   input  logic                i_ren,
   input  logic [ADDR_W-1:0]   i_addr,
   output logic [DATA_W-1:0]   i_load,
   output ram_state_t          i_state,
   // load/store master
   input  logic                d_ren,
   input  logic [DATA_W/8-1:0] d_wen,
   input  logic [ADDR_W-1:0]   d_addr,
   input  logic [DATA_W-1:0]   d_store,
   output logic [DATA_W-1:0]   d_load,
   output ram_state_t          d_state,
   // memory channel
   output logic                ram_ren,
   output logic [DATA_W/8-1:0] ram_wen,
   output logic [ADDR_W-1:0]   ram_addr,
   output logic [DATA_W-1:0]   ram_store,
   input  logic [DATA_W-1:0]   ram_load,
   input  ram_state_t          ram_state
);

   arb_state_t state, state_nxt;
   grant_t     last_grant, last_grant_nxt;
   grant_t     pick;
   logic       pick_valid;
   logic       i_req, d_req;
   logic       gnt_i, gnt_d;
   logic       first_cycle;

   assign i_req  = i_ren;
   assign d_req  = d_ren | (|d_wen);

   // Read data is shared; each master only trusts it on its own DONE.
   assign i_load = ram_load;
   assign d_load = ram_load;

   // Two-way round-robin pick: a tie goes to the master not served last.
   always_comb begin
      pick_valid = i_req | d_req;
      if (i_req && d_req) begin
         pick = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
      end else if (i_req) begin
         pick = GRANT_I;
      end else begin
         pick = GRANT_D;
      end
   end

   // State and round-robin history registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state      <= ARB_IDLE;
         last_grant <= GRANT_D;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   // Next-state, grant routing and status outputs.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      gnt_i          = 1'b0;
      gnt_d          = 1'b0;
      first_cycle    = 1'b0;
      ram_ren        = 1'b0;
      ram_wen        = '0;
      ram_addr       = '0;
      ram_store      = '0;
      i_state        = i_req ? RAM_WAIT : RAM_IDLE;
      d_state        = d_req ? RAM_WAIT : RAM_IDLE;

      unique case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               first_cycle    = 1'b1;
               last_grant_nxt = pick;
               if (pick == GRANT_I) begin
                  gnt_i     = 1'b1;
                  state_nxt = ARB_IBUSY;
               end else begin
                  gnt_d     = 1'b1;
                  state_nxt = ARB_DBUSY;
               end
            end
         end
         ARB_IBUSY: begin
            gnt_i = 1'b1;
            if (!i_req || ram_state == RAM_DONE) state_nxt = ARB_IDLE;
         end
         ARB_DBUSY: begin
            gnt_d = 1'b1;
            if (!d_req || ram_state == RAM_DONE) state_nxt = ARB_IDLE;
         end
         default: state_nxt = ARB_IDLE;
      endcase

      // While reset is held nothing reaches the memory and both masters see IDLE.
      if (!nrst) begin
         gnt_i   = 1'b0;
         gnt_d   = 1'b0;
         i_state = RAM_IDLE;
         d_state = RAM_IDLE;
      end

      // A stale DONE seen in the grant cycle belongs to no one.
      if (gnt_i) begin
         if (i_req) begin
            ram_ren  = i_ren;
            ram_addr = i_addr;
         end
         i_state = (first_cycle && ram_state == RAM_DONE) ? RAM_WAIT : ram_state;
      end

      if (gnt_d) begin
         if (d_req) begin
            ram_ren   = d_ren;
            ram_wen   = d_wen;
            ram_addr  = d_addr;
            ram_store = d_store;
         end
         d_state = (first_cycle && ram_state == RAM_DONE) ? RAM_WAIT : ram_state;
      end
   end

endmodule : mem_arbiter
